// File: rtl/alu_wide_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_wide_seq
// Purpose  : Runs 16-bit XOR / AND / ADD operations on an 8-bit combinational
//            ALU, one byte per cycle. Carry between the bytes is handled here
//            because the ALU ADD has no carry-in. A low-byte carry is folded
//            into the high byte by an extra "+1" pass through the ALU.
// Ports    : clk, reset_n (async, active-low)
//            req_valid/req_ready/req_op/req_a/req_b : request handshake
//                                                     (op 00 XOR, 01 AND,
//                                                      10 ADD, 11 illegal)
//            alu_cmd/alu_ina/alu_inb/alu_sc_i       : drive to the ALU
//            alu_rslt/alu_sc_o                      : result from the ALU
//            rsp_valid/rsp_ready/rsp_data/rsp_carry/
//            rsp_zero/rsp_err                       : response handshake
// Options  : ALU_WIDE_SEQ_PARITY_EN adds output rsp_parity (= ^rsp_data,
//            registered on entry to DONE).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_wide_seq #(
   parameter logic [2:0] CMD_NOP = 3'b000,
   parameter logic [2:0] CMD_XOR = 3'b011,
   parameter logic [2:0] CMD_AND = 3'b101,
   parameter logic [2:0] CMD_ADD = 3'b111
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic [2:0]  alu_cmd,
   output logic [7:0]  alu_ina,
   output logic [7:0]  alu_inb,
   output logic        alu_sc_i,
   input  logic [7:0]  alu_rslt,
   input  logic        alu_sc_o,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_carry,
   output logic        rsp_zero,
   output logic        rsp_err
`ifdef ALU_WIDE_SEQ_PARITY_EN
   ,
   output logic        rsp_parity
`endif
);

   localparam logic [1:0] OP_XOR = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_INC  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] data_q, data_d;
   logic        c_lo_q, c_lo_d;
   logic        c_hi_q, c_hi_d;
   logic        c_inc_q, c_inc_d;
   logic [2:0]  op_cmd;
   logic        is_add;

   // ALU command for the captured operation (illegal never reaches LO/HI)
   always_comb begin
      op_cmd = CMD_NOP;
      case (op_q)
         OP_XOR:  op_cmd = CMD_XOR;
         OP_AND:  op_cmd = CMD_AND;
         OP_ADD:  op_cmd = CMD_ADD;
         default: op_cmd = CMD_NOP;
      endcase
   end

   assign is_add = (op_q == OP_ADD);

   // Next-state, datapath capture and ALU drive
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      data_d  = data_q;
      c_lo_d  = c_lo_q;
      c_hi_d  = c_hi_q;
      c_inc_d = c_inc_q;
      alu_cmd = CMD_NOP;
      alu_ina = 8'h00;
      alu_inb = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               op_d    = req_op;
               // Cleared here so an illegal op responds with data 0
               data_d  = 16'h0000;
               c_lo_d  = 1'b0;
               c_hi_d  = 1'b0;
               c_inc_d = 1'b0;
               state_d = (req_op == OP_ILL) ? S_DONE : S_LO;
            end
         end
         S_LO: begin
            alu_cmd     = op_cmd;
            alu_ina     = a_q[7:0];
            alu_inb     = b_q[7:0];
            data_d[7:0] = alu_rslt;
            if (is_add) begin
               c_lo_d = alu_sc_o;
            end
            state_d = S_HI;
         end
         S_HI: begin
            alu_cmd      = op_cmd;
            alu_ina      = a_q[15:8];
            alu_inb      = b_q[15:8];
            data_d[15:8] = alu_rslt;
            if (is_add) begin
               c_hi_d = alu_sc_o;
            end
            state_d = (is_add && c_lo_q) ? S_INC : S_DONE;
         end
         S_INC: begin
            // Fold the low-byte carry into the high byte
            alu_cmd      = CMD_ADD;
            alu_ina      = data_q[15:8];
            alu_inb      = 8'h01;
            data_d[15:8] = alu_rslt;
            c_inc_d      = alu_sc_o;
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         op_q    <= 2'b00;
         data_q  <= 16'h0000;
         c_lo_q  <= 1'b0;
         c_hi_q  <= 1'b0;
         c_inc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         data_q  <= data_d;
         c_lo_q  <= c_lo_d;
         c_hi_q  <= c_hi_d;
         c_inc_q <= c_inc_d;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign alu_sc_i  = 1'b0;
   assign rsp_data  = data_q;
   // Flags come only from registers; gated so they read 0 outside DONE
   assign rsp_carry = rsp_valid & (c_hi_q | c_inc_q);
   assign rsp_zero  = rsp_valid & (data_q == 16'h0000);
   assign rsp_err   = rsp_valid & (op_q == OP_ILL);

`ifdef ALU_WIDE_SEQ_PARITY_EN
   logic parity_q, parity_d;

   // Sampled from the value data_q will hold once DONE is entered
   always_comb begin
      parity_d = parity_q;
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         parity_d = ^data_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign rsp_parity = parity_q;
`else
   // No parity output in this build
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_alu_wide_seq
// Purpose  : Self-checking bench for alu_wide_seq with a behavioural 8-bit ALU
//            and a transaction-level reference of the 16-bit results.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_alu_wide_seq;

   localparam logic [2:0] C_NOP = 3'b000;
   localparam logic [2:0] C_XOR = 3'b011;
   localparam logic [2:0] C_AND = 3'b101;
   localparam logic [2:0] C_ADD = 3'b111;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_a, req_b;
   logic [2:0]  alu_cmd;
   logic [7:0]  alu_ina, alu_inb;
   logic        alu_sc_i;
   logic [7:0]  alu_rslt;
   logic        alu_sc_o;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_carry, rsp_zero, rsp_err;
`ifdef ALU_WIDE_SEQ_PARITY_EN
   logic        rsp_parity;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_wide_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_cmd   (alu_cmd),
      .alu_ina   (alu_ina),
      .alu_inb   (alu_inb),
      .alu_sc_i  (alu_sc_i),
      .alu_rslt  (alu_rslt),
      .alu_sc_o  (alu_sc_o),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err)
`ifdef ALU_WIDE_SEQ_PARITY_EN
      ,
      .rsp_parity(rsp_parity)
`endif
   );

   // Behavioural 8-bit combinational ALU
   always_comb begin
      alu_rslt = 8'h00;
      alu_sc_o = 1'b0;
      case (alu_cmd)
         C_XOR:   alu_rslt = alu_ina ^ alu_inb;
         C_AND:   alu_rslt = alu_ina & alu_inb;
         C_ADD:   {alu_sc_o, alu_rslt} = {1'b0, alu_ina} + {1'b0, alu_inb};
         default: alu_rslt = 8'h00;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model + per-cycle compare, sampled on the falling edge
   int          cyc = 0;
   bit          busy = 1'b0;
   int          acc, lat, ncmd, expn;
   logic [15:0] ea, eb, ed;
   logic        ec, ee;
   logic [2:0]  ecmd;
   logic [16:0] sum17;
   logic [8:0]  sum_lo;
   logic [7:0]  hi_sum;
   bit          ev;

   always @(negedge clk) begin
      cyc++;
      chk("alu_sc_i", {31'd0, alu_sc_i}, 32'd0);
      if (!reset_n) begin
         chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
         chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("rst_rsp_data",  {16'd0, rsp_data},  32'd0);
         chk("rst_flags",     {29'd0, rsp_carry, rsp_zero, rsp_err}, 32'd0);
         chk("rst_alu",       {13'd0, alu_cmd, alu_ina, alu_inb}, 32'd0);
`ifdef ALU_WIDE_SEQ_PARITY_EN
         chk("rst_parity",    {31'd0, rsp_parity}, 32'd0);
`endif
         busy = 1'b0;
      end else begin
         chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
         ev = busy && (cyc >= acc + lat);
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
         if (ev) begin
            chk("rsp_data",  {16'd0, rsp_data},  {16'd0, ed});
            chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, ec});
            chk("rsp_zero",  {31'd0, rsp_zero},  {31'd0, (ed == 16'h0000)});
            chk("rsp_err",   {31'd0, rsp_err},   {31'd0, ee});
            chk("alu_cmd_done", {29'd0, alu_cmd}, {29'd0, C_NOP});
`ifdef ALU_WIDE_SEQ_PARITY_EN
            chk("rsp_parity", {31'd0, rsp_parity}, {31'd0, ^ed});
`endif
         end
         if (!busy) begin
            chk("alu_idle", {13'd0, alu_cmd, alu_ina, alu_inb}, 32'd0);
         end else if (ee) begin
            chk("alu_cmd_illegal", {29'd0, alu_cmd}, {29'd0, C_NOP});
         end else begin
            if (alu_cmd == ecmd) ncmd++;
            if (cyc == acc + 1)
               chk("alu_lo_opnds", {16'd0, alu_ina, alu_inb}, {16'd0, ea[7:0], eb[7:0]});
            if (cyc == acc + 2)
               chk("alu_hi_opnds", {16'd0, alu_ina, alu_inb}, {16'd0, ea[15:8], eb[15:8]});
            if (lat == 4 && cyc == acc + 3) begin
               hi_sum = ea[15:8] + eb[15:8];
               chk("alu_inc", {13'd0, alu_cmd, alu_ina, alu_inb},
                   {13'd0, C_ADD, hi_sum, 8'h01});
            end
         end
         if (ev && rsp_ready) begin
            chk("alu_cmd_cycles", ncmd, expn);
            busy = 1'b0;
         end else if (!busy && req_valid) begin
            busy = 1'b1;
            acc  = cyc;
            ea   = req_a;
            eb   = req_b;
            ncmd = 0;
            ec   = 1'b0;
            ee   = 1'b0;
            lat  = 3;
            sum_lo = {1'b0, req_a[7:0]} + {1'b0, req_b[7:0]};
            case (req_op)
               2'b00: begin ed = req_a ^ req_b; ecmd = C_XOR; end
               2'b01: begin ed = req_a & req_b; ecmd = C_AND; end
               2'b10: begin
                  sum17 = {1'b0, req_a} + {1'b0, req_b};
                  ed    = sum17[15:0];
                  ec    = sum17[16];
                  ecmd  = C_ADD;
                  if (sum_lo[8]) lat = 4;
               end
               default: begin ed = 16'h0000; ee = 1'b1; lat = 1; ecmd = C_NOP; end
            endcase
            expn = ee ? 0 : ((lat == 4) ? 3 : 2);
         end
      end
   end

   // One directed transaction with hand-computed expectations.
   // Entered and left #1 after a rising edge with the DUT idle.
   task automatic run(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input int stall, input logic [15:0] xd, input logic xc, input int xlat);
      int n;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      rsp_ready = (stall == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, xlat);
      chk("dir_data", {16'd0, rsp_data}, {16'd0, xd});
      chk("dir_carry", {31'd0, rsp_carry}, {31'd0, xc});
      if (stall > 0) begin
         repeat (stall) begin @(posedge clk); #1; end
         chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data_held", {16'd0, rsp_data}, {16'd0, xd});
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("back_to_idle", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_a     = 16'h0000;
      req_b     = 16'h0000;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      run(2'b00, 16'hF0F0, 16'h0FF0, 0, 16'hFF00, 1'b0, 3);
      run(2'b10, 16'h00FF, 16'h0001, 0, 16'h0100, 1'b0, 4);
      run(2'b10, 16'hFFFF, 16'h0001, 0, 16'h0000, 1'b1, 4);
      run(2'b01, 16'h1234, 16'h0F0F, 5, 16'h0204, 1'b0, 3);
      run(2'b11, 16'hABCD, 16'h1234, 0, 16'h0000, 1'b0, 1);
      run(2'b10, 16'h1280, 16'h0180, 0, 16'h1400, 1'b0, 4);
      run(2'b10, 16'h8000, 16'h8000, 0, 16'h0000, 1'b1, 3);
      run(2'b00, 16'hAAAA, 16'hAAAA, 0, 16'h0000, 1'b0, 3);
      run(2'b10, 16'h1234, 16'h0101, 0, 16'h1335, 1'b0, 3);

      // Reset while the ADD16 is in its high-byte cycle
      req_valid = 1'b1;
      req_op    = 2'b10;
      req_a     = 16'h00FF;
      req_b     = 16'h0001;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_hi_cmd", {29'd0, alu_cmd}, {29'd0, C_ADD});
      reset_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_alu", {13'd0, alu_cmd, alu_ina, alu_inb}, 32'd0);
      chk("mid_rst_data", {16'd0, rsp_data}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
      run(2'b00, 16'h1234, 16'hFFFF, 0, 16'hEDCB, 1'b0, 3);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
